// File: rtl/id_ex_stage_if.sv
//------------------------------------------------------------------------------
// id_ex_stage_if : ID-side, forwarding and ID/EX boundary signals of the stage
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface id_ex_stage_if #(
   parameter int DATA_W = 32
);
   logic              id_valid;
   logic [31:0]       id_pc;
   logic [31:0]       id_inst;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [4:0]        rR1;
   logic [4:0]        rR2;
   logic [DATA_W-1:0] rD1;
   logic [DATA_W-1:0] rD2;
   logic              ex_wE;
   logic              ex_is_load;
   logic [4:0]        ex_wR;
   logic [DATA_W-1:0] ex_wdata;
   logic              mem_wE;
   logic [4:0]        mem_wR;
   logic [DATA_W-1:0] mem_wdata;
   logic              wb_wE;
   logic [4:0]        wb_wR;
   logic [DATA_W-1:0] wb_wdata;
   logic              ex_hold;
   logic              flush;
   logic              id_stall;
   logic              ex_valid;
   logic [31:0]       ex_pc;
   logic [31:0]       ex_inst;
   logic [DATA_W-1:0] ex_op1;
   logic [DATA_W-1:0] ex_op2;
   logic [4:0]        ex_rs1;
   logic [4:0]        ex_rs2;
   logic [4:0]        ex_rd;

   modport master (
      output id_valid, id_pc, id_inst, id_use_rs1, id_use_rs2, rD1, rD2,
             ex_wE, ex_is_load, ex_wR, ex_wdata, mem_wE, mem_wR, mem_wdata,
             wb_wE, wb_wR, wb_wdata, ex_hold, flush,
      input  rR1, rR2, id_stall, ex_valid, ex_pc, ex_inst, ex_op1, ex_op2,
             ex_rs1, ex_rs2, ex_rd
   );

   modport slave (
      input  id_valid, id_pc, id_inst, id_use_rs1, id_use_rs2, rD1, rD2,
             ex_wE, ex_is_load, ex_wR, ex_wdata, mem_wE, mem_wR, mem_wdata,
             wb_wE, wb_wR, wb_wdata, ex_hold, flush,
      output rR1, rR2, id_stall, ex_valid, ex_pc, ex_inst, ex_op1, ex_op2,
             ex_rs1, ex_rs2, ex_rd
   );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// id_ex_stage : operand fetch, forwarding, hazard detection, ID/EX register
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter bit FWD_EN = 1'b1
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   id_ex_stage_if.slave  bus
);
   localparam logic [4:0] c_R0 = 5'd0;

   logic [4:0]        w_rs1;
   logic [4:0]        w_rs2;
   logic              w_ex1, w_mem1, w_wb1;
   logic              w_ex2, w_mem2, w_wb2;
   logic              w_hazard;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;

   logic              r_valid;
   logic [31:0]       r_pc;
   logic [31:0]       r_inst;
   logic [DATA_W-1:0] r_op1;
   logic [DATA_W-1:0] r_op2;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_rd;

   assign w_rs1   = bus.id_inst[19:15];
   assign w_rs2   = bus.id_inst[24:20];
   assign bus.rR1 = w_rs1;
   assign bus.rR2 = w_rs2;

   // A source only matches a stage that writes a non-zero register it reads
   assign w_ex1  = bus.id_use_rs1 & bus.ex_wE  & (bus.ex_wR  != c_R0) & (bus.ex_wR  == w_rs1);
   assign w_mem1 = bus.id_use_rs1 & bus.mem_wE & (bus.mem_wR != c_R0) & (bus.mem_wR == w_rs1);
   assign w_wb1  = bus.id_use_rs1 & bus.wb_wE  & (bus.wb_wR  != c_R0) & (bus.wb_wR  == w_rs1);
   assign w_ex2  = bus.id_use_rs2 & bus.ex_wE  & (bus.ex_wR  != c_R0) & (bus.ex_wR  == w_rs2);
   assign w_mem2 = bus.id_use_rs2 & bus.mem_wE & (bus.mem_wR != c_R0) & (bus.mem_wR == w_rs2);
   assign w_wb2  = bus.id_use_rs2 & bus.wb_wE  & (bus.wb_wR  != c_R0) & (bus.wb_wR  == w_rs2);

   generate
      if (FWD_EN) begin : g_fwd
         always_comb begin
            w_op1 = bus.rD1;
            if (w_ex1)       w_op1 = bus.ex_wdata;
            else if (w_mem1) w_op1 = bus.mem_wdata;
            else if (w_wb1)  w_op1 = bus.wb_wdata;
         end

         always_comb begin
            w_op2 = bus.rD2;
            if (w_ex2)       w_op2 = bus.ex_wdata;
            else if (w_mem2) w_op2 = bus.mem_wdata;
            else if (w_wb2)  w_op2 = bus.wb_wdata;
         end

         // Only a load in EX has no result yet; everything else is forwardable
         assign w_hazard = bus.ex_is_load & (w_ex1 | w_ex2);
      end else begin : g_nofwd
         assign w_op1    = bus.rD1;
         assign w_op2    = bus.rD2;
         assign w_hazard = w_ex1 | w_mem1 | w_wb1 | w_ex2 | w_mem2 | w_wb2;
      end
   endgenerate

   assign bus.id_stall = bus.id_valid & ~bus.flush & (w_hazard | bus.ex_hold);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_inst  <= '0;
         r_op1   <= '0;
         r_op2   <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
      end else if (bus.ex_hold) begin
         r_valid <= r_valid;
      end else if (w_hazard) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= bus.id_valid;
         r_pc    <= bus.id_pc;
         r_inst  <= bus.id_inst;
         r_op1   <= w_op1;
         r_op2   <= w_op2;
         r_rs1   <= w_rs1;
         r_rs2   <= w_rs2;
         r_rd    <= bus.id_inst[11:7];
      end
   end

   assign bus.ex_valid = r_valid;
   assign bus.ex_pc    = r_pc;
   assign bus.ex_inst  = r_inst;
   assign bus.ex_op1   = r_op1;
   assign bus.ex_op2   = r_op2;
   assign bus.ex_rs1   = r_rs1;
   assign bus.ex_rs2   = r_rs2;
   assign bus.ex_rd    = r_rd;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

Operand-fetch and ID/EX pipeline register stage of the pipelined core. It drives the register-file read addresses from the instruction in ID and merges the returned read data with forwarded results from EX, MEM and WB. It detects load-use and structural hazards and registers the resolved operands into the ID/EX boundary, with stall and flush control. It sits between the decoder and the execute stage.

## Interface
- `DATA_W`, 32: operand/data width.
- `FWD_EN`, 1: 1 = full forwarding; 0 = no forwarding, stall on every RAW hazard.
- `clk` input 1: clock, all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `id_valid` input 1: instruction in ID is valid.
- `id_pc` input 32: PC of ID instruction.
- `id_inst` input 32: ID instruction (RV32 encoding: rs1=[19:15], rs2=[24:20], rd=[11:7]).
- `id_use_rs1`, `id_use_rs2` input 1 each: decoder flags that the source is actually read.
- `rR1`, `rR2` output 5 each: register-file read addresses, combinational = id_inst[19:15] and id_inst[24:20].
- `rD1`, `rD2` input DATA_W each: register-file read data (combinational, r0 reads 0).
- `ex_wE`, `ex_is_load` input 1; `ex_wR` input 5; `ex_wdata` input DATA_W: EX-stage result (ALU output).
- `mem_wE` input 1; `mem_wR` input 5; `mem_wdata` input DATA_W: MEM-stage result (load data included).
- `wb_wE` input 1; `wb_wR` input 5; `wb_wdata` input DATA_W: WB value currently being written to the register file.
- `ex_hold` input 1: EX cannot accept (multi-cycle op).
- `flush` input 1: branch/jump redirect from EX; kill ID instruction.
- `id_stall` output 1: combinational; ID/IF must hold their contents this cycle.
- `ex_valid` output 1; `ex_pc`, `ex_inst` output 32; `ex_op1`, `ex_op2` output DATA_W; `ex_rs1`, `ex_rs2`, `ex_rd` output 5: registered ID/EX contents.

## Operation
- Match: srcN matches stage S when S_wE=1, S_wR≠0, S_wR=rsN, id_use_rsN=1.
- Forward mux per source (FWD_EN=1), priority EX > MEM > WB > rDN. rsN=0 or id_use_rsN=0 yields rDN unmodified; r0 therefore always 0.
- Load-use hazard: a source matches EX with ex_is_load=1. Stall 1 cycle. The EX load then sits in MEM and is forwarded from mem_wdata.
- FWD_EN=0: any match against EX, MEM or WB is a hazard. ex_op = rDN only.
- `id_stall` = id_valid & ~flush & (hazard | ex_hold).
- ID/EX register update, priority order:
  1. rst_n=0: all outputs 0.
  2. flush=1: ex_valid←0; other fields don't-care (held).
  3. ex_hold=1: hold all ID/EX fields.
  4. hazard=1: bubble, ex_valid←0; the ID instruction is not consumed.
  5. Otherwise: ex_valid←id_valid, and the pc/inst/op/rs/rd fields load from ID.
- `ex_rd` = id_inst[11:7], passed unmodified; the write-enable decision belongs to the downstream decode.
- A bubble or invalid slot never asserts a hazard against later instructions. Upstream gates S_wE with that stage's valid.

## Timing
- Reset: ex_valid=0, ex_pc=0, ex_inst=0, ex_op1=0, ex_op2=0, ex_rs1=0, ex_rs2=0, ex_rd=0. rR1/rR2/id_stall follow inputs combinationally. id_stall=0 when id_valid=0.
- Latency: 1 cycle from ID inputs to ID/EX outputs.
- Load-use: exactly 1 bubble cycle, then the instruction issues with MEM-forwarded data.
- WB forwarding covers the same-cycle write (regfile write lands at the edge, read is pre-edge).
- flush and hazard in the same cycle: flush wins, id_stall=0, bubble.
- flush with ex_hold: flush wins; ex_valid←0.
- ex_hold with hazard: hold wins; hazard is re-evaluated next cycle.
- rst_n low mid-stall: clears at next edge. id_stall then depends only on current inputs.

## Test plan
- Reset: rst_n=0 for 2 cycles with random inputs, then release -> all ex_* = 0 and ex_valid=0 during and after the first edge.
- EX forward priority: ID `add x3,x1,x2` with rD1=0x11; EX wR=1 data 0xAA, MEM wR=1 data 0xBB, WB wR=1 data 0xCC -> ex_op1=0xAA, no stall. Drop EX -> 0xBB. Drop MEM -> 0xCC.
- r0 guard: rs1=0, EX wR=0 wE=1 data 0xDEAD -> ex_op1=rD1=0, id_stall=0.
- Load-use: EX `lw x5` (ex_is_load=1, wR=5), ID uses x5 -> id_stall=1, ex_valid=0 next cycle. Next cycle, with MEM wR=5 data 0x1234 -> ex_op1=0x1234, ex_valid=1.
- Flush vs stall: load-use hazard with flush=1 the same cycle -> id_stall=0, ex_valid=0. ex_hold=1 for 3 cycles -> ID/EX fields unchanged, id_stall=1 throughout.
- FWD_EN=0: MEM wR=2 matches rs2 -> id_stall=1 until no stage matches. The instruction then issues with ex_op2=rD2.
